// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: config field layout, sequencer states, pe_in_valid bit indices and per-phase word counts
package pe_ctrl_pkg;
    localparam int CFG_W    = 13;
    localparam int DW_BIT   = 12;
    localparam int RS_LSB   = 10;
    localparam int MODE_BIT = 9;
    localparam int P_LSB    = 7;
    localparam int F_LSB    = 2;
    localparam int F_W      = 5;
    localparam int Q_LSB    = 0;
    localparam int V_FILTER = 0;
    localparam int V_IFMAP  = 1;
    localparam int V_DW     = 2;
    localparam int V_PW     = 3;
    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_FILTER, S_IFMAP, S_DWPS, S_PWPS, S_OPSUM, S_DONE
    } state_t;
    // Fields hold value-1; first_col selects the full rs-word ifmap load of column 0.
    function automatic logic [5:0] phase_count(input state_t s, input logic dw, input logic [1:0] rs_f,
                                               input logic [1:0] p_f, input logic [1:0] q_f, input logic first_col);
        logic [5:0] rs, p, q;
        rs = {4'd0, rs_f} + 6'd1;
        p  = {4'd0, p_f} + 6'd1;
        q  = {4'd0, q_f} + 6'd1;
        return s == S_FILTER ? p * rs :
               s == S_IFMAP  ? (first_col ? rs : 6'd1) :
               (s == S_DWPS || s == S_OPSUM) ? (dw ? q : p) :
               (s == S_PWPS && dw) ? p : 6'd0;
    endfunction
endpackage

// File: rtl/pe_word_stage.sv
// pe_word_stage: one-entry operand staging register with a read-in-flight flag
//   rd_issue  in  GLB read issued this cycle (data returns next cycle)
//   rd_data   in  GLB read data
//   consume   in  staged word transferred to the PE this cycle
//   full      out register holds a word
//   inflight  out a read is outstanding
//   data      out staged word
module pe_word_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_issue,
    input  logic [31:0] rd_data,
    input  logic        consume,
    output logic        full,
    output logic        inflight,
    output logic [31:0] data
);
    // A read is only issued while empty, so a return never collides with a consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            inflight <= 1'b0;
            data     <= '0;
        end else begin
            inflight <= rd_issue;
            if (inflight) begin
                full <= 1'b1;
                data <= rd_data;
            end else if (consume) begin
                full <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pe_job_sequencer.sv
// pe_job_sequencer: runs one PE through a layer job (config load, operand streaming from GLB, opsum write-back)
//   job_*        job request/handshake, config word and GLB base addresses
//   busy, done   status; done pulses once per completed job
//   glb_rd_*     GLB read port, 1-cycle read latency
//   glb_wr_*     GLB write port, always accepted
//   pe_*         PE config load, shared operand bus with one-hot channel valids, opsum handshake
module pe_job_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int AW = 16,
    parameter int CW = CFG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [CW-1:0] job_config,
    input  logic [AW-1:0] job_in_base,
    input  logic [AW-1:0] job_out_base,
    output logic          busy,
    output logic          done,
    output logic          glb_rd_en,
    output logic [AW-1:0] glb_rd_addr,
    input  logic [31:0]   glb_rd_data,
    output logic          glb_wr_en,
    output logic [AW-1:0] glb_wr_addr,
    output logic [31:0]   glb_wr_data,
    output logic          pe_en,
    output logic [CW-1:0] pe_config,
    output logic [31:0]   pe_data,
    output logic [3:0]    pe_in_valid,
    input  logic [3:0]    pe_in_ready,
    input  logic [31:0]   pe_opsum,
    input  logic          pe_opsum_valid,
    output logic          pe_opsum_ready
);
    state_t          state, nxt;
    logic [CW-1:0]   cfg_q;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [5:0]      cnt, total;
    logic [F_W-1:0]  col;
    logic            full, inflight, in_phase, xfer, last;
    logic [31:0]     stage_data;

    pe_word_stage u_stage (
        .clk      (clk),
        .rst      (rst),
        .rd_issue (glb_rd_en),
        .rd_data  (glb_rd_data),
        .consume  (xfer),
        .full     (full),
        .inflight (inflight),
        .data     (stage_data)
    );

    assign total = phase_count(state, cfg_q[DW_BIT], cfg_q[RS_LSB +: 2], cfg_q[P_LSB +: 2],
                               cfg_q[Q_LSB +: 2], col == '0);
    assign glb_rd_addr = rd_ptr;
    assign glb_wr_addr = wr_ptr;
    assign pe_config   = cfg_q;
    assign pe_data     = stage_data;

    always_comb begin
        nxt            = state;
        job_ready      = state == S_IDLE;
        busy           = state != S_IDLE;
        done           = state == S_DONE;
        pe_en          = state == S_CFG;
        pe_opsum_ready = state == S_OPSUM;
        in_phase       = state inside {S_FILTER, S_IFMAP, S_DWPS, S_PWPS};
        // cnt counts transfers; with one word staged or in flight, cnt < total means words remain to read.
        glb_rd_en      = in_phase && !full && !inflight && cnt < total;
        glb_wr_en      = pe_opsum_ready && pe_opsum_valid;
        glb_wr_data    = glb_wr_en ? pe_opsum : '0;
        pe_in_valid           = '0;
        pe_in_valid[V_FILTER] = full && state == S_FILTER;
        pe_in_valid[V_IFMAP]  = full && state == S_IFMAP;
        pe_in_valid[V_DW]     = full && state == S_DWPS;
        pe_in_valid[V_PW]     = full && state == S_PWPS;
        xfer = |(pe_in_valid & pe_in_ready);
        last = (xfer || glb_wr_en) && cnt == total - 6'd1;
        case (state)
            S_IDLE:   nxt = job_valid ? S_CFG : S_IDLE;
            S_CFG:    nxt = S_FILTER;
            S_FILTER: nxt = last ? S_IFMAP : S_FILTER;
            S_IFMAP:  nxt = last ? S_DWPS : S_IFMAP;
            // pw_ipsum is empty for non-dw jobs, so that phase is bypassed.
            S_DWPS:   nxt = last ? (cfg_q[DW_BIT] ? S_PWPS : S_OPSUM) : S_DWPS;
            S_PWPS:   nxt = last ? S_OPSUM : S_PWPS;
            S_OPSUM:  nxt = last ? (col == cfg_q[F_LSB +: F_W] ? S_DONE : S_IFMAP) : S_OPSUM;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cfg_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            col    <= '0;
        end else begin
            state <= nxt;
            if (last)
                cnt <= '0;
            else if (xfer || glb_wr_en)
                cnt <= cnt + 6'd1;
            if (state == S_IDLE && job_valid) begin
                cfg_q  <= job_config;
                rd_ptr <= job_in_base;
                wr_ptr <= job_out_base;
                col    <= '0;
            end
            if (glb_rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (glb_wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (state == S_OPSUM && last)
                col <= col + 1'b1;
        end
    end
endmodule
